// File: rtl/ysyx_2022040010_wb_commit_if.sv
// Bundle of the commit queue's retire, LSU return, hazard query and regfile write signals.
// The commit queue is the slave; whoever feeds it retiring instructions is the master.
interface ysyx_2022040010_wb_commit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic              in_wen;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              in_is_load;
    logic              lsu_rvalid;
    logic [DATA_W-1:0] lsu_rdata;
    logic [ADDR_W-1:0] q_addr1;
    logic [ADDR_W-1:0] q_addr2;
    logic              q_busy1;
    logic              q_busy2;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              commit_valid;
    logic              lsu_err;

    modport master (
        output in_valid, in_wen, in_rd, in_data, in_is_load,
        output lsu_rvalid, lsu_rdata, q_addr1, q_addr2,
        input  in_ready, q_busy1, q_busy2, we, waddr, wdata, commit_valid, lsu_err
    );

    modport slave (
        input  in_valid, in_wen, in_rd, in_data, in_is_load,
        input  lsu_rvalid, lsu_rdata, q_addr1, q_addr2,
        output in_ready, q_busy1, q_busy2, we, waddr, wdata, commit_valid, lsu_err
    );
endinterface

// File: rtl/ysyx_2022040010_wb_commit.sv
// In-order writeback/commit queue: holds retiring instructions, waits for load data,
// and drives the regfile write port one entry per cycle through registered outputs.
module ysyx_2022040010_wb_commit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input logic clk,
    input logic rst,
    ysyx_2022040010_wb_commit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              pending;
    } entry_t;

    entry_t            ent [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;

    logic              ready;
    logic              enq;
    logic              pop;
    logic              fill_hit;
    logic [PTR_W-1:0]  fill_idx;
    logic [PTR_W-1:0]  idx;
    logic              busy1;
    logic              busy2;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cv_q;
    logic              err_q;

    // No pop-through: a full queue refuses input even when the head retires this cycle.
    assign ready = (count < (PTR_W+1)'(DEPTH));
    assign enq   = bus.in_valid && ready;
    assign pop   = ent[head].valid && !ent[head].pending;

    // Oldest pending entry: walk youngest-to-oldest from head so the oldest hit wins.
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = '0;
        idx      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = head + PTR_W'(i);
            if (ent[idx].valid && ent[idx].pending) begin
                fill_hit = 1'b1;
                fill_idx = idx;
            end
        end
    end

    // The registered output stage is excluded; the regfile forwards it itself.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].valid && ent[i].wen && ent[i].rd == bus.q_addr1) busy1 = 1'b1;
            if (ent[i].valid && ent[i].wen && ent[i].rd == bus.q_addr2) busy2 = 1'b1;
        end
        if (bus.q_addr1 == '0) busy1 = 1'b0;
        if (bus.q_addr2 == '0) busy2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (bus.lsu_rvalid) begin
                if (fill_hit) begin
                    ent[fill_idx].data    <= bus.lsu_rdata;
                    ent[fill_idx].pending <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end

            if (pop) begin
                ent[head].valid <= 1'b0;
                head            <= head + PTR_W'(1);
                cv_q            <= 1'b1;
                we_q            <= ent[head].wen && (ent[head].rd != '0);
                waddr_q         <= ent[head].rd;
                wdata_q         <= ent[head].data;
            end else begin
                cv_q <= 1'b0;
                we_q <= 1'b0;
            end

            // Tail slot is free whenever ready, so it never collides with head or fill.
            if (enq) begin
                ent[tail].valid   <= 1'b1;
                ent[tail].wen     <= bus.in_wen;
                ent[tail].rd      <= bus.in_rd;
                ent[tail].data    <= bus.in_is_load ? '0 : bus.in_data;
                ent[tail].pending <= bus.in_is_load;
                tail              <= tail + PTR_W'(1);
            end

            count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
        end
    end

    assign bus.in_ready     = ready;
    assign bus.q_busy1      = busy1;
    assign bus.q_busy2      = busy2;
    assign bus.we           = we_q;
    assign bus.waddr        = waddr_q;
    assign bus.wdata        = wdata_q;
    assign bus.commit_valid = cv_q;
    assign bus.lsu_err      = err_q;
endmodule
